// File: rtl/uart_tx_control_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | DataTypes : shared types for the UART transmit path               |
// | Rev 1.0   : initial release                                       |
// +-------------------------------------------------------------------+
package DataTypes;

  typedef logic bit_t;

  localparam int bitspertx = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uartTxState_t;

  // Baud counter sized for the default 434-cycle bit period; instances
  // with other rates size their counters from CLKS_PER_BIT directly.
  localparam int c_default_clks_per_bit = 434;
  typedef logic [$clog2(c_default_clks_per_bit)-1:0] uartBaudCount_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_control_baud_tick.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_baud_tick : bit-period divider, one-cycle tick per bit       |
// | Rev 1.0        : initial release                                  |
// +-------------------------------------------------------------------+
module uart_baud_tick
  import DataTypes::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            enable,
  output bit_t                            tick,
  output logic [$clog2(CLKS_PER_BIT)-1:0] count
);

  localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_count;

  assign tick  = enable && (r_count == c_last);
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_control.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | uart_tx_control : UART transmit FSM, LSB-first with opt. parity   |
// | Rev 1.0         : initial release                                 |
// +-------------------------------------------------------------------+
module uart_tx_control
  import DataTypes::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = bitspertx,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 bit_counter,
  output logic                 increment_bit_counter,
  output logic                 reset_bit_counter,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
  // tx_done is registered, so it is armed one count before the final tick.
  localparam logic [c_cnt_w-1:0] c_done_cnt = c_cnt_w'(CLKS_PER_BIT - 2);

  uartTxState_t         r_state;
  logic [DATA_BITS-1:0] r_shift;
  bit_t                 r_parity;
  logic [DATA_BITS-1:0] w_shift_next;
  bit_t                 w_tick;
  logic [c_cnt_w-1:0]   w_count;

  assign w_shift_next = r_shift >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state == TX_IDLE),
    .enable (r_state != TX_IDLE),
    .tick   (w_tick),
    .count  (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state               <= TX_IDLE;
      r_shift               <= '0;
      r_parity              <= 1'b0;
      tx                    <= 1'b1;
      tx_busy               <= 1'b0;
      tx_done               <= 1'b0;
      increment_bit_counter <= 1'b0;
      reset_bit_counter     <= 1'b0;
    end else begin
      increment_bit_counter <= 1'b0;
      reset_bit_counter     <= 1'b0;
      tx_done               <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            r_shift           <= tx_data;
            r_parity          <= 1'b0;
            reset_bit_counter <= 1'b1;
            tx                <= 1'b0;
            tx_busy           <= 1'b1;
            r_state           <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            tx      <= r_shift[0];
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            r_parity <= r_parity ^ r_shift[0];
            if (!bit_counter) begin
              increment_bit_counter <= 1'b1;
              r_shift               <= w_shift_next;
              tx                    <= w_shift_next[0];
            end else if (PARITY_EN) begin
              tx      <= r_parity ^ r_shift[0] ^ PARITY_ODD;
              r_state <= TX_PARITY;
            end else begin
              tx      <= 1'b1;
              r_state <= TX_STOP;
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            tx      <= 1'b1;
            r_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_count == c_done_cnt) begin
            tx_done <= 1'b1;
          end
          if (w_tick) begin
            tx_busy <= 1'b0;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
